// File: rtl/systolic_feeder.sv
// systolic_feeder: loads one 4x4 weight tile, emits it row by row, then streams NVEC skewed activation vectors.
// Optional stall counter output is built when SYSTOLIC_FEEDER_PERF_EN is defined.
module systolic_feeder #(
  parameter int NVEC  = 4,
  parameter int DRAIN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wt_valid,
  output logic             wt_ready,
  input  logic [3:0][31:0] wt_data,
  input  logic             act_valid,
  output logic             act_ready,
  input  logic [3:0][31:0] act_data,
  output logic [3:0][31:0] a_out,
  output logic [3:0]       a_vld,
  output logic [3:0][31:0] b_out,
  output logic             switch_out,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_EMIT_W = 3'd2,
    S_SWITCH = 3'd3,
    S_STREAM = 3'd4,
    S_FLUSH  = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  localparam logic [7:0] NVEC_LAST  = 8'(NVEC - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

  state_t                 state_r, state_s;
  logic [7:0]             cnt_r, cnt_s;
  logic [3:0][3:0][31:0]  wbuf_r;
  logic [3:0][31:0]       b_s;
  logic [3:0][31:0]       head_d_s;
  logic                   wt_hs_s;
  logic                   act_hs_s;
  logic                   done_s;

  // The ready registers are only high inside their own phase, so they qualify the handshakes.
  assign wt_hs_s  = wt_valid & wt_ready;
  assign act_hs_s = act_valid & act_ready;
  assign head_d_s = act_hs_s ? act_data : {4{32'd0}};

  // Next-state and phase counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD_W;
          cnt_s   = 8'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (wt_hs_s && (cnt_r == 8'd3)) begin
          state_s = S_EMIT_W;
          cnt_s   = 8'd0;
        end else if (wt_hs_s) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_EMIT_W: begin
        if (cnt_r == 8'd3) begin
          state_s = S_SWITCH;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_SWITCH: begin
        state_s = S_STREAM;
        cnt_s   = 8'd0;
      end
      S_STREAM: begin
        if (act_hs_s && (cnt_r == NVEC_LAST)) begin
          state_s = S_FLUSH;
          cnt_s   = 8'd0;
        end else if (act_hs_s) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_FLUSH: begin
        if (cnt_r == 8'd2) begin
          state_s = S_DRAIN;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s = S_IDLE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    done_s = (state_r == S_DRAIN) && (cnt_r == DRAIN_LAST);
    if (state_s == S_EMIT_W) begin
      b_s = wbuf_r[cnt_s[1:0]];
    end else begin
      b_s = {4{32'd0}};
    end
  end

  // Control state, weight buffer and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 8'd0;
      wbuf_r     <= {16{32'd0}};
      wt_ready   <= 1'b0;
      act_ready  <= 1'b0;
      b_out      <= {4{32'd0}};
      switch_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      if (wt_hs_s) begin
        wbuf_r[cnt_r[1:0]] <= wt_data;
      end
      wt_ready   <= (state_s == S_LOAD_W);
      act_ready  <= (state_s == S_STREAM);
      b_out      <= b_s;
      switch_out <= (state_s == S_SWITCH);
      busy       <= (state_s != S_IDLE) || done_s;
      done       <= done_s;
    end
  end

  // Lane i delays by 1+i registers; the oldest stage drives the array row.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [i:0][31:0] pd_r;
    logic [i:0]       pv_r;

    // Skew shift chain for this lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pd_r <= {(i+1){32'd0}};
        pv_r <= {(i+1){1'b0}};
      end else begin
        pd_r <= (pd_r << 6'd32) | (32*(i+1))'(head_d_s[i]);
        pv_r <= (pv_r << 1'b1) | (i+1)'(act_hs_s);
      end
    end

    assign a_out[i] = pd_r[i];
    assign a_vld[i] = pv_r[i];
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  // Bubble counter over STREAM cycles, saturating and held after the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if ((state_r == S_IDLE) && start) begin
      stall_cnt <= 16'd0;
    end else if ((state_r == S_STREAM) && !act_hs_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: a schedule model predicts every output per cycle of each job.
// Exercises SYSTOLIC_FEEDER_PERF_EN's stall_cnt when that macro is defined.
module tb_systolic_feeder;

  localparam int NVEC  = 4;
  localparam int DRAIN = 8;
  localparam int MAXO  = 320;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             wt_valid = 1'b0;
  logic             wt_ready;
  logic [3:0][31:0] wt_data = '0;
  logic             act_valid = 1'b0;
  logic             act_ready;
  logic [3:0][31:0] act_data = '0;
  logic [3:0][31:0] a_out;
  logic [3:0]       a_vld;
  logic [3:0][31:0] b_out;
  logic             switch_out;
  logic             busy;
  logic             done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]      stall_cnt;
`endif

  systolic_feeder #(.NVEC(NVEC), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .a_out(a_out), .a_vld(a_vld), .b_out(b_out), .switch_out(switch_out),
    .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // Per-job stimulus, indexed by cycle offset from the start cycle (offset 0).
  bit               wv [MAXO];
  logic [3:0][31:0] wd [MAXO];
  bit               av [MAXO];
  logic [3:0][31:0] ad [MAXO];

  // Expected outputs per offset.
  bit               e_wr [MAXO];
  bit               e_ar [MAXO];
  bit               e_sw [MAXO];
  bit               e_busy [MAXO];
  bit               e_done [MAXO];
  logic [3:0][31:0] e_b [MAXO];
  logic [3:0][31:0] e_a [MAXO];
  logic [3:0]       e_v [MAXO];
  int lend, ss, send, dn, stalls;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wt_ready"}, 128'(wt_ready), 128'd0);
    check_val({tag, "_act_ready"}, 128'(act_ready), 128'd0);
    check_val({tag, "_a_out"}, 128'(a_out), 128'd0);
    check_val({tag, "_a_vld"}, 128'(a_vld), 128'd0);
    check_val({tag, "_b_out"}, 128'(b_out), 128'd0);
    check_val({tag, "_switch"}, 128'(switch_out), 128'd0);
    check_val({tag, "_busy"}, 128'(busy), 128'd0);
    check_val({tag, "_done"}, 128'(done), 128'd0);
  endtask

  task automatic gen(input int wprob, input int aprob);
    for (int o = 0; o < MAXO; o++) begin
      wv[o] = (o > 30) || ($urandom_range(0, 99) < wprob);
      av[o] = (o > 100) || ($urandom_range(0, 99) < aprob);
      for (int j = 0; j < 4; j++) begin
        wd[o][j] = $urandom;
        ad[o][j] = $urandom;
      end
    end
  endtask

  // Schedule model: phases follow from handshake counts; outputs follow from the schedule.
  task automatic build_model();
    logic [3:0][31:0] rows [4];
    int k;
    int o;
    for (int c = 0; c < MAXO; c++) begin
      e_wr[c] = 1'b0; e_ar[c] = 1'b0; e_sw[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
      e_b[c] = '0; e_a[c] = '0; e_v[c] = '0;
    end
    k = 0;
    o = 1;
    while (k < 4) begin
      if (wv[o]) begin
        rows[k] = wd[o];
        k++;
      end
      o++;
    end
    lend = o - 1;
    for (int c = 1; c <= lend; c++) e_wr[c] = 1'b1;
    for (int r = 0; r < 4; r++) e_b[lend + 1 + r] = rows[r];
    e_sw[lend + 5] = 1'b1;
    ss = lend + 6;
    k = 0;
    o = ss;
    while (k < NVEC) begin
      e_ar[o] = 1'b1;
      if (av[o]) begin
        for (int i = 0; i < 4; i++) begin
          e_a[o + 1 + i][i] = ad[o][i];
          e_v[o + 1 + i][i] = 1'b1;
        end
        k++;
      end
      o++;
    end
    send = o - 1;
    stalls = (send - ss + 1) - NVEC;
    dn = send + 4 + DRAIN;
    for (int c = 1; c <= dn; c++) e_busy[c] = 1'b1;
    e_done[dn] = 1'b1;
  endtask

  // started=1: the caller already holds start high in the current (IDLE) cycle.
  task automatic run_job(input bit started, input bit hold, input int abort_at);
    int last;
    last = (abort_at > 0) ? abort_at : dn;
    if (!started) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    for (int o = 1; o <= last; o++) begin
      @(posedge clk); #1;
      cyc++;
      start     = hold;
      wt_valid  = wv[o];
      wt_data   = wd[o];
      act_valid = av[o];
      act_data  = ad[o];
      @(negedge clk);
      check_val("wt_ready", 128'(wt_ready), 128'(e_wr[o]));
      check_val("act_ready", 128'(act_ready), 128'(e_ar[o]));
      check_val("b_out", 128'(b_out), 128'(e_b[o]));
      check_val("switch_out", 128'(switch_out), 128'(e_sw[o]));
      check_val("busy", 128'(busy), 128'(e_busy[o]));
      check_val("done", 128'(done), 128'(e_done[o]));
      check_val("a_out", 128'(a_out), 128'(e_a[o]));
      check_val("a_vld", 128'(a_vld), 128'(e_v[o]));
`ifdef SYSTOLIC_FEEDER_PERF_EN
      if (o == dn) check_val("stall_cnt", 128'(stall_cnt), 128'(stalls));
`endif
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      cyc++;
      start     = 1'b0;
      wt_valid  = 1'($urandom_range(0, 1));
      act_valid = 1'($urandom_range(0, 1));
      wt_data   = {$urandom, $urandom, $urandom, $urandom};
      act_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_zero("idle");
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_zero("por");
`ifdef SYSTOLIC_FEEDER_PERF_EN
    check_val("por_stall", 128'(stall_cnt), 128'd0);
`endif
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // Directed: continuous valids, weights row k = k+1, vectors 0x10+4k+lane.
    gen(100, 100);
    for (int o = 1; o <= 4; o++)
      for (int j = 0; j < 4; j++) wd[o][j] = 32'(o);
    for (int o = 10; o < MAXO; o++)
      for (int i = 0; i < 4; i++) ad[o][i] = 32'(16 + 4 * (o - 10) + i);
    build_model();
    run_job(1'b0, 1'b0, 0);
    idle_cycles(2);

    // Directed: gappy weight stream 1,0,0,1,1,0,1.
    gen(60, 60);
    wv[1] = 1'b1; wv[2] = 1'b0; wv[3] = 1'b0; wv[4] = 1'b1;
    wv[5] = 1'b1; wv[6] = 1'b0; wv[7] = 1'b1;
    build_model();
    run_job(1'b0, 1'b0, 0);
    idle_cycles(2);

    // Directed: two bubbles right after the first vector.
    gen(100, 100);
    av[11] = 1'b0;
    av[12] = 1'b0;
    build_model();
    run_job(1'b0, 1'b0, 0);
    idle_cycles(2);

    // Random jobs over a range of valid densities.
    for (int t = 0; t < 4; t++) begin
      gen(30 + 20 * t, 80 - 15 * t);
      build_model();
      run_job(1'b0, 1'b0, 0);
      idle_cycles(1 + t);
    end

    // Reset in the middle of STREAM, asserted between clock edges.
    gen(70, 70);
    build_model();
    run_job(1'b0, 1'b0, ss + 2);
    #1 rst = 1'b1;
    #1 check_zero("rst_mid");
`ifdef SYSTOLIC_FEEDER_PERF_EN
    check_val("rst_stall", 128'(stall_cnt), 128'd0);
`endif
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    idle_cycles(DRAIN + 6);

    // Fresh job after the abandoned one.
    gen(50, 50);
    build_model();
    run_job(1'b0, 1'b0, 0);
    idle_cycles(2);

    // start held high through a job: the next job follows the done cycle directly.
    gen(80, 80);
    build_model();
    run_job(1'b0, 1'b1, 0);
    gen(60, 60);
    build_model();
    run_job(1'b1, 1'b0, 0);
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
